// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: arbitrates fetch and data ports onto one registered memory bus,
// with round-robin tie break and a bus_ready wait-cycle timeout.
module memory_bus_arbiter #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_ack,
    output logic [31:0] i_read_data,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_write_data,
    input  logic [3:0]  d_byte_enable,
    output logic        d_ack,
    output logic [31:0] d_read_data,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic [31:0] bus_read_data,
    input  logic        bus_ready,
    output logic        bus_timeout
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t     state_q;
    logic       last_data_q;
    logic [7:0] wait_q;
    logic       abort;
    logic       done;
    logic       grant_fetch;

    // The WAIT_LIMIT-th low cycle aborts instead of incrementing the counter.
    assign abort       = !bus_ready && wait_q == 8'(WAIT_LIMIT - 1);
    assign done        = bus_ready || abort;
    assign grant_fetch = i_req && (!d_req || last_data_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            last_data_q      <= 1'b1;
            wait_q           <= '0;
            i_ack            <= 1'b0;
            d_ack            <= 1'b0;
            i_read_data      <= '0;
            d_read_data      <= '0;
            bus_address      <= '0;
            bus_write_data   <= '0;
            bus_byte_enable  <= '0;
            bus_read_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_timeout      <= 1'b0;
        end else begin
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_read_data <= '0;
            d_read_data <= '0;
            bus_timeout <= 1'b0;
            if (state_q == IDLE) begin
                wait_q <= '0;
                if (grant_fetch) begin
                    state_q          <= FETCH;
                    last_data_q      <= 1'b0;
                    bus_address      <= i_address;
                    bus_write_data   <= '0;
                    bus_byte_enable  <= 4'b1111;
                    bus_read_enable  <= 1'b1;
                    bus_write_enable <= 1'b0;
                end else if (d_req) begin
                    state_q          <= DATA;
                    last_data_q      <= 1'b1;
                    bus_address      <= d_address;
                    bus_write_data   <= d_write_data;
                    bus_byte_enable  <= d_byte_enable;
                    bus_read_enable  <= !d_write;
                    bus_write_enable <= d_write;
                end
            end else if (done) begin
                state_q          <= IDLE;
                bus_address      <= '0;
                bus_write_data   <= '0;
                bus_byte_enable  <= '0;
                bus_read_enable  <= 1'b0;
                bus_write_enable <= 1'b0;
                bus_timeout      <= abort;
                if (state_q == FETCH) begin
                    i_ack       <= 1'b1;
                    i_read_data <= abort ? '0 : bus_read_data;
                end else begin
                    d_ack       <= 1'b1;
                    d_read_data <= (abort || bus_write_enable) ? '0 : bus_read_data;
                end
            end else begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed scenarios checked every cycle against a transaction-level
// model of the arbiter, plus literal latency/data expectations.
module tb_memory_bus_arbiter;
    localparam int WL = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_address = '0;
    logic        i_ack;
    logic [31:0] i_read_data;
    logic        d_req = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_address = '0;
    logic [31:0] d_write_data = '0;
    logic [3:0]  d_byte_enable = '0;
    logic        d_ack;
    logic [31:0] d_read_data;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data = '0;
    logic        bus_ready = 1'b0;
    logic        bus_timeout;

    int checks = 0;
    int failures = 0;

    memory_bus_arbiter #(.WAIT_LIMIT(WL)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_read_data(i_read_data),
        .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_write_data(d_write_data),
        .d_byte_enable(d_byte_enable), .d_ack(d_ack), .d_read_data(d_read_data),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data),
        .bus_ready(bus_ready), .bus_timeout(bus_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, its recorded fields and its wait count.
    bit          m_busy, m_data_port, m_wr, m_last_data;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    int          m_waits;
    bit          e_iack, e_dack, e_to;
    logic [31:0] e_ird, e_drd;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_last_data = 1; m_waits = 0;
            e_iack = 0; e_dack = 0; e_to = 0; e_ird = 0; e_drd = 0;
        end else begin
            e_iack = 0; e_dack = 0; e_to = 0;
            if (!m_busy) begin
                if (i_req && (!d_req || m_last_data)) begin
                    m_busy = 1; m_data_port = 0; m_addr = i_address; m_waits = 0; m_last_data = 0;
                end else if (d_req) begin
                    m_busy = 1; m_data_port = 1; m_addr = d_address; m_wd = d_write_data;
                    m_be = d_byte_enable; m_wr = d_write; m_waits = 0; m_last_data = 1;
                end
            end else begin
                bit fin, tout;
                fin = bus_ready;
                tout = 0;
                if (!bus_ready) begin
                    m_waits++;
                    if (m_waits == WL) begin fin = 1; tout = 1; end
                end
                if (fin) begin
                    m_busy = 0;
                    e_to = tout;
                    if (m_data_port) begin
                        e_dack = 1;
                        e_drd = (tout || m_wr) ? 32'd0 : bus_read_data;
                    end else begin
                        e_iack = 1;
                        e_ird = tout ? 32'd0 : bus_read_data;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("bus_address", bus_address, m_busy ? m_addr : 32'd0);
        chk("bus_write_data", bus_write_data, (m_busy && m_data_port) ? m_wd : 32'd0);
        chk("bus_byte_enable", {28'd0, bus_byte_enable}, !m_busy ? 32'd0 : m_data_port ? {28'd0, m_be} : 32'hF);
        chk("bus_read_enable", {31'd0, bus_read_enable}, {31'd0, m_busy && !(m_data_port && m_wr)});
        chk("bus_write_enable", {31'd0, bus_write_enable}, {31'd0, m_busy && m_data_port && m_wr});
        chk("i_ack", {31'd0, i_ack}, {31'd0, e_iack});
        chk("d_ack", {31'd0, d_ack}, {31'd0, e_dack});
        chk("bus_timeout", {31'd0, bus_timeout}, {31'd0, e_to});
        chk("exclusive", {30'd0, i_ack & d_ack, bus_read_enable & bus_write_enable}, 32'd0);
        if (e_iack) chk("i_read_data", i_read_data, e_ird);
        if (e_dack) chk("d_read_data", d_read_data, e_drd);
    end

    // Waits up to lim falling edges for the chosen ack; n is the number of edges it took.
    task automatic await_ack(input bit dport, input int lim, output int n);
        bit seen = 0;
        for (n = 1; n <= lim; n++) begin
            @(negedge clock);
            if (dport ? d_ack : i_ack) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL await_%s: no ack within %0d cycles", dport ? "d_ack" : "i_ack", lim);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clock);
        chk("reset_re", {31'd0, bus_read_enable}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single fetch, memory ready immediately
        i_req = 1; i_address = 32'h100; bus_ready = 1; bus_read_data = 32'h13;
        @(negedge clock);
        chk("fetch_re", {31'd0, bus_read_enable}, 32'd1);
        chk("fetch_addr", bus_address, 32'h100);
        await_ack(0, 5, n);
        chk("fetch_latency", n + 1, 32'd2);
        chk("fetch_data", i_read_data, 32'h13);
        i_req = 0;
        @(negedge clock);

        // Tie after reset-state arbitration, then alternation; data port re-requests in its ack cycle
        reset = 1'b1; #1 reset = 1'b0;
        i_req = 1; i_address = 32'h200; d_req = 1; d_write = 0; d_address = 32'h40;
        d_byte_enable = 4'b1111; bus_read_data = 32'h55;
        await_ack(0, 5, n);
        chk("tie1_fetch_first", n, 32'd2);
        i_req = 0;
        await_ack(1, 5, n);
        chk("tie1_data_next", n, 32'd2);
        chk("tie1_data", d_read_data, 32'h55);
        i_req = 1;
        await_ack(0, 5, n);
        chk("tie2_fetch", n, 32'd2);
        i_req = 0;
        await_ack(1, 5, n);
        d_req = 0;
        @(negedge clock);

        // Store with 3 wait cycles; requester fields change after grant
        bus_ready = 0; bus_read_data = 32'hAAAA5555;
        d_req = 1; d_write = 1; d_address = 32'h2004; d_write_data = 32'hDEADBEEF; d_byte_enable = 4'b0011;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            chk("store_addr", bus_address, 32'h2004);
            chk("store_wdata", bus_write_data, 32'hDEADBEEF);
            chk("store_be", {28'd0, bus_byte_enable}, 32'h3);
            chk("store_we", {31'd0, bus_write_enable}, 32'd1);
            d_address = 32'hFFFF_0000; d_write_data = 32'h0; d_byte_enable = 4'b1100; d_write = 0;
        end
        bus_ready = 1;
        @(negedge clock);
        chk("store_ack", {31'd0, d_ack}, 32'd1);
        chk("store_rdata", d_read_data, 32'd0);
        d_req = 0; bus_ready = 0;
        @(negedge clock);

        // Load timeout; request dropped right after grant still completes
        d_req = 1; d_write = 0; d_address = 32'h3000; d_byte_enable = 4'b1111;
        @(negedge clock);
        d_req = 0;
        await_ack(1, 30, n);
        chk("timeout_latency", n + 1, 32'd17);
        chk("timeout_pulse", {31'd0, bus_timeout}, 32'd1);
        chk("timeout_rdata", d_read_data, 32'd0);
        @(negedge clock);
        chk("timeout_idle", {31'd0, bus_read_enable}, 32'd0);

        // Reset in the middle of a fetch
        i_req = 1; i_address = 32'h400;
        repeat (2) @(negedge clock);
        chk("mid_re_before", {31'd0, bus_read_enable}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("mid_re_after", {31'd0, bus_read_enable}, 32'd0);
        chk("mid_addr_after", bus_address, 32'd0);
        @(negedge clock);
        reset = 1'b0; i_req = 0;
        repeat (3) @(negedge clock);
        i_req = 1; i_address = 32'h500; bus_ready = 1; bus_read_data = 32'h77;
        await_ack(0, 5, n);
        chk("post_reset_latency", n, 32'd2);
        chk("post_reset_data", i_read_data, 32'h77);
        i_req = 0;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
